muldiv_unit: RTL and testbench

- Parametrised iterative multiply/divide unit for the pipelined MIPS core.
- Sits beside the execution stage and owns the HI/LO registers.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the execution stage and runs multiply/divide over a fixed number of cycles.
- Raises busy so decode can stall MFHI/MFLO and further mul/div ops; supports flush on branch/jump squash.

---
 rtl/muldiv_unit.sv | 150 +++++++++++++++
 tb/tb_muldiv_unit.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// Shift-add multiply and restoring divide on magnitudes, sign fix at the end.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam int AW = 2 * WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [AW-1:0]    acc;
    logic [WIDTH-1:0] mcand;
    logic             neg_lo;
    logic             neg_hi;
    logic             div0;
    logic             is_div;

    logic             sgn;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH:0]   step_sum;
    logic [AW-1:0]    mul_next;
    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   diff;
    logic [AW-1:0]    div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    // Operand magnitudes and one iteration of each algorithm.
    // acc upper part is the partial product / running remainder,
    // acc lower part holds the multiplier / dividend bits being consumed.
    always_comb begin
        sgn      = ~op[0];
        mag_a    = (sgn && src_a[WIDTH-1]) ? -src_a : src_a;
        mag_b    = (sgn && src_b[WIDTH-1]) ? -src_b : src_b;
        step_sum = acc[AW-1:WIDTH] + (acc[0] ? {1'b0, mcand} : '0);
        mul_next = {1'b0, step_sum, acc[WIDTH-1:1]};
        r_shift  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff     = r_shift - {1'b0, mcand};
        div_next = diff[WIDTH]
                 ? {r_shift, acc[WIDTH-2:0], 1'b0}
                 : {diff, acc[WIDTH-2:0], 1'b1};
        prod_fix = neg_lo ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
        quo_fix  = div0 ? '1
                 : (neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
        rem_fix  = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    // Control FSM, iteration datapath and HI/LO register file.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            div0   <= 1'b0;
            is_div <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start && !flush) begin
                        case (op)
                            3'd0, 3'd1: begin
                                state  <= S_MUL;
                                busy   <= 1'b1;
                                cnt    <= CW'(WIDTH - 1);
                                acc    <= {{(WIDTH + 1){1'b0}}, mag_b};
                                mcand  <= mag_a;
                                neg_lo <= sgn & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                                neg_hi <= 1'b0;
                                div0   <= 1'b0;
                                is_div <= 1'b0;
                            end
                            3'd2, 3'd3: begin
                                state  <= S_DIV;
                                busy   <= 1'b1;
                                cnt    <= CW'(WIDTH - 1);
                                acc    <= {{(WIDTH + 1){1'b0}}, mag_a};
                                mcand  <= mag_b;
                                neg_lo <= sgn & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                                neg_hi <= sgn & src_a[WIDTH-1];
                                div0   <= (src_b == '0);
                                is_div <= 1'b1;
                            end
                            3'd4:    hi <= src_a;
                            3'd5:    lo <= src_a;
                            default: ;
                        endcase
                    end
                end
                S_MUL, S_DIV: begin
                    if (flush) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        acc <= (state == S_MUL) ? mul_next : div_next;
                        if (cnt == '0) begin
                            state <= S_FIX;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                S_FIX: begin
                    // Commit point: flush no longer cancels the result.
                    if (is_div) begin
                        lo <= quo_fix;
                        hi <= rem_fix;
                    end else begin
                        lo <= prod_fix[WIDTH-1:0];
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH=32).
// Directed plan cases plus random ops against an arithmetic model.
module tb_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // MIPS HI/LO semantics computed with plain 64-bit arithmetic.
    task automatic model(input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      sq;
        longint      sr;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            3'd0: begin
                p = 64'(sa * sb);
                exp_hi = p[63:32];
                exp_lo = p[31:0];
            end
            3'd1: begin
                p = {32'b0, a} * {32'b0, b};
                exp_hi = p[63:32];
                exp_lo = p[31:0];
            end
            3'd2: begin
                if (b == 0) begin
                    exp_lo = 32'hFFFF_FFFF;
                    exp_hi = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    exp_lo = 32'h8000_0000;
                    exp_hi = 32'h0;
                end else begin
                    sq = sa / sb;
                    sr = sa % sb;
                    exp_lo = sq[31:0];
                    exp_hi = sr[31:0];
                end
            end
            3'd3: begin
                if (b == 0) begin
                    exp_lo = 32'hFFFF_FFFF;
                    exp_hi = a;
                end else begin
                    exp_lo = a / b;
                    exp_hi = a % b;
                end
            end
            3'd4: exp_hi = a;
            3'd5: exp_lo = a;
            default: ;
        endcase
    endtask

    // Issue a mul/div, scramble operands, then count busy cycles until done.
    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input bit fix_flush);
        int bcnt;
        int guard;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        @(negedge clk);
        start = 1'b0;
        src_a = $urandom;
        src_b = $urandom;
        bcnt  = 0;
        guard = 0;
        while (!done && guard < 100) begin
            if (busy) bcnt++;
            if (fix_flush && bcnt == 33) flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
            guard++;
        end
        model(o, a, b);
        check({tag, " done"}, 64'(done), 64'd1);
        check({tag, " busy_cycles"}, 64'(bcnt), 64'd33);
        check({tag, " busy_at_done"}, 64'(busy), 64'd0);
        check({tag, " hi"}, 64'(hi), 64'(exp_hi));
        check({tag, " lo"}, 64'(lo), 64'(exp_lo));
        @(negedge clk);
        check({tag, " done_pulse"}, 64'(done), 64'd0);
        check({tag, " idle_after"}, 64'(busy), 64'd0);
    endtask

    // Register moves and no-ops: one-edge update, never busy or done.
    task automatic run_mt(input string tag, input logic [2:0] o,
                          input logic [31:0] a);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = $urandom;
        @(negedge clk);
        start = 1'b0;
        model(o, a, 32'h0);
        check({tag, " hi"}, 64'(hi), 64'(exp_hi));
        check({tag, " lo"}, 64'(lo), 64'(exp_lo));
        check({tag, " busy"}, 64'(busy), 64'd0);
        check({tag, " done"}, 64'(done), 64'd0);
    endtask

    initial begin
        int          ndone;
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        rst   = 1'b0;
        start = 1'b0;
        op    = 3'd0;
        src_a = '0;
        src_b = '0;
        flush = 1'b0;
        repeat (2) @(negedge clk);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        rst = 1'b1;

        run_op("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd7, 1'b0);
        check("mult_neg hi_const", 64'(hi), 64'hFFFF_FFFF);
        check("mult_neg lo_const", 64'(lo), 64'hFFFF_FFEB);
        run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("multu_max hi_const", 64'(hi), 64'hFFFF_FFFE);
        run_op("mult_m1m1", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("div_neg lo_const", 64'(lo), 64'hFFFF_FFFD);
        run_op("divu_7_2", 3'd3, 32'd7, 32'd2, 1'b0);
        run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("divu_zero", 3'd3, 32'h1234, 32'h0, 1'b0);
        check("divu_zero hi_const", 64'(hi), 64'h1234);
        run_op("div_zero_neg", 3'd2, 32'h8000_0005, 32'h0, 1'b0);
        run_op("fix_flush", 3'd1, 32'h0001_0003, 32'h0000_0101, 1'b1);

        run_mt("mthi", 3'd4, 32'hAAAA_5555);
        run_mt("mtlo", 3'd5, 32'h5555_AAAA);
        run_mt("nop6", 3'd6, 32'hDEAD_BEEF);

        // start with flush in IDLE is dropped
        @(negedge clk);
        start = 1'b1;
        flush = 1'b1;
        op    = 3'd4;
        src_a = 32'h1111_2222;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        check("flush_start hi", 64'(hi), 64'(exp_hi));
        check("flush_start busy", 64'(busy), 64'd0);

        // MTHI while busy is ignored and not queued
        @(negedge clk);
        start = 1'b1;
        op    = 3'd3;
        src_a = 32'd100;
        src_b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        op    = 3'd4;
        src_a = 32'hCAFE_F00D;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("mthi_busy hi", 64'(hi), 64'(exp_hi));
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        model(3'd3, 32'd100, 32'd7);
        check("mthi_busy ndone", 64'(ndone), 64'd1);
        check("mthi_busy hi_final", 64'(hi), 64'(exp_hi));
        check("mthi_busy lo_final", 64'(lo), 64'(exp_lo));

        // flush mid-multiply: no result, no done
        @(negedge clk);
        start = 1'b1;
        op    = 3'd0;
        src_a = 32'h1234_5678;
        src_b = 32'h9ABC_DEF0;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush busy", 64'(busy), 64'd0);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            if (done || busy) ndone++;
            @(negedge clk);
        end
        check("flush no_done", 64'(ndone), 64'd0);
        check("flush hi", 64'(hi), 64'(exp_hi));
        check("flush lo", 64'(lo), 64'(exp_lo));

        // reset mid-multiply clears everything
        @(negedge clk);
        start = 1'b1;
        op    = 3'd1;
        src_a = 32'h0F0F_0F0F;
        src_b = 32'h1357_9BDF;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_hi = '0;
        exp_lo = '0;
        check("midreset busy", 64'(busy), 64'd0);
        check("midreset hi", 64'(hi), 64'd0);
        check("midreset lo", 64'(lo), 64'd0);
        run_op("after_reset", 3'd0, 32'hFFFF_FF00, 32'h0000_0300, 1'b0);

        for (int n = 0; n < 40; n++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: rb = 32'hFFFF_FFFF;
                2: ra = 32'h8000_0000;
                3: rb = 32'($urandom_range(1, 9));
                default: ;
            endcase
            if (ro <= 3'd3) run_op("rand", ro, ra, rb, 1'b0);
            else run_mt("rand_mt", ro, ra);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
